// File: rtl/out_wrap_pkg.sv
// Shared types and constants for the FP multiplier output wrapper.
package out_wrap_pkg;

  // Handshake FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // IEEE-754 single-precision field layout.
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MANT_W  = 23;

  // Bit positions inside the 4-bit classification word {nan,inf,zero,sign}.
  localparam int NAN  = 3;
  localparam int INF  = 2;
  localparam int ZERO = 1;
  localparam int SIGN = 0;

endpackage

// File: rtl/out_wrapper_cu_fp32_class.sv
// Combinational FP32 classifier: produces {nan,inf,zero,sign} for one operand.
module fp32_class
  import out_wrap_pkg::*;
(
  input  logic [31:0] i_value,
  output logic [3:0]  o_flags
);

  logic [EXP_MSB-EXP_LSB:0] w_exp;
  logic [MANT_W-1:0]        w_mant;
  logic                     w_exp_ones;
  logic                     w_exp_zero;
  logic                     w_mant_zero;

  assign w_exp       = i_value[EXP_MSB:EXP_LSB];
  assign w_mant      = i_value[MANT_W-1:0];
  assign w_exp_ones  = &w_exp;
  assign w_exp_zero  = ~|w_exp;
  assign w_mant_zero = ~|w_mant;

  // Decode the exponent/mantissa patterns into the flag word.
  always_comb begin
    o_flags       = '0;
    o_flags[NAN]  = w_exp_ones & ~w_mant_zero;
    o_flags[INF]  = w_exp_ones & w_mant_zero;
    o_flags[ZERO] = w_exp_zero & w_mant_zero;
    o_flags[SIGN] = i_value[31];
  end

endmodule

// File: rtl/out_wrapper_cu.sv
// Output wrapper for the FP multiplier: captures a product on fp_done and
// hands it to the host LS-slice first over a 4-phase ready/accept handshake.
// Optional feature macro: OUT_WRAP_FLAGS_EN adds the fp_flags classification port.
module out_wrapper_cu
  import out_wrap_pkg::*;
#(
  parameter int DATA_W = 32,  // product width, integer multiple of OUT_W
  parameter int OUT_W  = 32   // host bus width; DATA_W/OUT_W of 1, 2 or 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fp_done,
  input  logic [DATA_W-1:0] fp_result,
  input  logic              out_accept,
  input  logic              ovf_clr,
  output logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              wrap_free,
  output logic              overflow
`ifdef OUT_WRAP_FLAGS_EN
  ,
  output logic [3:0]        fp_flags
`endif
);

  localparam int BEATS = DATA_W / OUT_W;
  // Counter is at least one bit wide so the single-beat build stays legal.
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLOTS = 1 << CNT_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_res_q;
  logic [OUT_W-1:0]  r_out_data;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [CNT_W-1:0]  w_beat_next;
  logic              r_overflow;
  logic              w_capture;
  logic              w_advance;
  logic [OUT_W-1:0]  w_slices [SLOTS];

  // Slice table; unused slots (counter padding) read as zero.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slice
      if (gi < BEATS) begin : g_real
        assign w_slices[gi] = r_res_q[gi*OUT_W +: OUT_W];
      end else begin : g_pad
        assign w_slices[gi] = '0;
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and datapath-control decode.
  always_comb begin
    w_state_next = r_state;
    w_beat_next  = r_beat_cnt;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      IDLE: begin
        if (fp_done) begin
          w_capture    = 1'b1;
          w_state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (out_accept) w_state_next = RELEASE;
      end
      RELEASE: begin
        if (!out_accept) begin
          if (r_beat_cnt == LAST_BEAT) begin
            w_beat_next  = '0;
            w_state_next = IDLE;
          end else begin
            w_beat_next  = r_beat_cnt + 1'b1;
            w_advance    = 1'b1;
            w_state_next = PRESENT;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Product capture, beat counter and output beat register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_q    <= '0;
      r_out_data <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_capture) begin
        r_res_q    <= fp_result;
        r_out_data <= fp_result[OUT_W-1:0];
      end else if (w_advance) begin
        r_out_data <= w_slices[w_beat_next];
      end
      r_beat_cnt <= w_beat_next;
    end
  end

  // Sticky overflow: a product arriving while busy wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_overflow <= 1'b0;
    else if (fp_done && r_state != IDLE)  r_overflow <= 1'b1;
    else if (ovf_clr)                     r_overflow <= 1'b0;
  end

  assign out_ready = (r_state == PRESENT);
  assign wrap_free = (r_state == IDLE);
  assign out_data  = r_out_data;
  assign overflow  = r_overflow;

`ifdef OUT_WRAP_FLAGS_EN
  logic [3:0] w_flags;
  logic [3:0] r_flags;

  fp32_class u_class (
    .i_value (fp_result[31:0]),
    .o_flags (w_flags)
  );

  // Flags track the captured product and hold until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_flags <= '0;
    else if (w_capture) r_flags <= w_flags;
  end

  assign fp_flags = r_flags;
`endif

endmodule

// File: tb/tb_out_wrapper_cu.sv
// Directed self-checking bench for out_wrapper_cu: one 32-bit-bus instance and
// one 16-bit-bus (two-beat) instance. Flag checks build with OUT_WRAP_FLAGS_EN.
module tb_out_wrapper_cu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        d32_done, d32_acc, d32_clr;
  logic [31:0] d32_res;
  logic        d32_ready, d32_free, d32_ovf;
  logic [31:0] d32_data;
`ifdef OUT_WRAP_FLAGS_EN
  logic [3:0]  d32_flags;
  logic [3:0]  d16_flags;
`endif

  logic        d16_done, d16_acc, d16_clr;
  logic [31:0] d16_res;
  logic        d16_ready, d16_free, d16_ovf;
  logic [15:0] d16_data;

  int checks = 0;
  int errors = 0;

  out_wrapper_cu #(.DATA_W(32), .OUT_W(32)) u_dut32 (
    .clk        (clk),
    .rst_n      (rst_n),
    .fp_done    (d32_done),
    .fp_result  (d32_res),
    .out_accept (d32_acc),
    .ovf_clr    (d32_clr),
    .out_ready  (d32_ready),
    .out_data   (d32_data),
    .wrap_free  (d32_free),
    .overflow   (d32_ovf)
`ifdef OUT_WRAP_FLAGS_EN
    ,
    .fp_flags   (d32_flags)
`endif
  );

  out_wrapper_cu #(.DATA_W(32), .OUT_W(16)) u_dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .fp_done    (d16_done),
    .fp_result  (d16_res),
    .out_accept (d16_acc),
    .ovf_clr    (d16_clr),
    .out_ready  (d16_ready),
    .out_data   (d16_data),
    .wrap_free  (d16_free),
    .overflow   (d16_ovf)
`ifdef OUT_WRAP_FLAGS_EN
    ,
    .fp_flags   (d16_flags)
`endif
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (d32_ready !== 1'b0) begin errors++; $display("FAIL rst_ready32 got %0b want 0", d32_ready); end
    checks++; if (d32_free !== 1'b1) begin errors++; $display("FAIL rst_free32 got %0b want 1", d32_free); end
    checks++; if (d32_data !== 32'h0) begin errors++; $display("FAIL rst_data32 got %h want 00000000", d32_data); end
    checks++; if (d32_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf32 got %0b want 0", d32_ovf); end
    checks++; if (d16_ready !== 1'b0 || d16_free !== 1'b1) begin errors++; $display("FAIL rst_hs16 got ready=%0b free=%0b want 0/1", d16_ready, d16_free); end
    checks++; if (d16_data !== 16'h0) begin errors++; $display("FAIL rst_data16 got %h want 0000", d16_data); end
`ifdef OUT_WRAP_FLAGS_EN
    checks++; if (d32_flags !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b want 0000", d32_flags); end
`endif
    rst_n = 1'b1;
    tick();
    checks++; if (d32_free !== 1'b1 || d32_ready !== 1'b0) begin errors++; $display("FAIL rst_idle32 got free=%0b ready=%0b want 1/0", d32_free, d32_ready); end
    $display("txn reset: outputs idle");
  endtask

  task automatic test_single_beat();
    d32_res = 32'h40490FDB; d32_done = 1'b1;
    tick();
    d32_done = 1'b0;
    checks++; if (d32_ready !== 1'b1) begin errors++; $display("FAIL t1_ready got %0b want 1", d32_ready); end
    checks++; if (d32_data !== 32'h40490FDB) begin errors++; $display("FAIL t1_data got %h want 40490fdb", d32_data); end
    checks++; if (d32_free !== 1'b0) begin errors++; $display("FAIL t1_busy got %0b want 0", d32_free); end
    repeat (3) tick();
    checks++; if (d32_ready !== 1'b1) begin errors++; $display("FAIL t1_hold got %0b want 1", d32_ready); end
    d32_acc = 1'b1;
    tick();
    checks++; if (d32_ready !== 1'b0 || d32_free !== 1'b0) begin errors++; $display("FAIL t1_release got ready=%0b free=%0b want 0/0", d32_ready, d32_free); end
    d32_acc = 1'b0;
    tick();
    checks++; if (d32_free !== 1'b1 || d32_ready !== 1'b0) begin errors++; $display("FAIL t1_idle got free=%0b ready=%0b want 1/0", d32_free, d32_ready); end
    checks++; if (d32_data !== 32'h40490FDB) begin errors++; $display("FAIL t1_data_kept got %h want 40490fdb", d32_data); end
    $display("txn single_beat: product 40490fdb delivered in one beat");
  endtask

  task automatic test_two_beat();
    d16_res = 32'hC0000000; d16_done = 1'b1;
    tick();
    d16_done = 1'b0;
    checks++; if (d16_ready !== 1'b1 || d16_data !== 16'h0000) begin errors++; $display("FAIL t2_beat0 got ready=%0b data=%h want 1/0000", d16_ready, d16_data); end
    d16_acc = 1'b1;
    tick();
    checks++; if (d16_ready !== 1'b0) begin errors++; $display("FAIL t2_rel0 got %0b want 0", d16_ready); end
    d16_acc = 1'b0;
    tick();
    checks++; if (d16_ready !== 1'b1 || d16_data !== 16'hC000) begin errors++; $display("FAIL t2_beat1 got ready=%0b data=%h want 1/c000", d16_ready, d16_data); end
    checks++; if (d16_free !== 1'b0) begin errors++; $display("FAIL t2_busy got %0b want 0", d16_free); end
    d16_acc = 1'b1;
    tick();
    d16_acc = 1'b0;
    tick();
    checks++; if (d16_free !== 1'b1 || d16_ready !== 1'b0) begin errors++; $display("FAIL t2_idle got free=%0b ready=%0b want 1/0", d16_free, d16_ready); end
    $display("txn two_beat: product c0000000 delivered as 0000,c000");
  endtask

  task automatic test_accept_early();
    d16_acc = 1'b1;
    tick();
    checks++; if (d16_free !== 1'b1 || d16_ready !== 1'b0) begin errors++; $display("FAIL t3_idle_ignore got free=%0b ready=%0b want 1/0", d16_free, d16_ready); end
    d16_res = 32'h12345678; d16_done = 1'b1;
    tick();
    d16_done = 1'b0;
    checks++; if (d16_ready !== 1'b1 || d16_data !== 16'h5678) begin errors++; $display("FAIL t3_beat0 got ready=%0b data=%h want 1/5678", d16_ready, d16_data); end
    tick();
    checks++; if (d16_ready !== 1'b0 || d16_data !== 16'h5678) begin errors++; $display("FAIL t3_short got ready=%0b data=%h want 0/5678", d16_ready, d16_data); end
    tick();
    checks++; if (d16_ready !== 1'b0 || d16_free !== 1'b0) begin errors++; $display("FAIL t3_wait got ready=%0b free=%0b want 0/0", d16_ready, d16_free); end
    d16_acc = 1'b0;
    tick();
    checks++; if (d16_ready !== 1'b1 || d16_data !== 16'h1234) begin errors++; $display("FAIL t3_beat1 got ready=%0b data=%h want 1/1234", d16_ready, d16_data); end
    tick();
    checks++; if (d16_ready !== 1'b1) begin errors++; $display("FAIL t3_beat1_hold got %0b want 1", d16_ready); end
    d16_acc = 1'b1;
    tick();
    d16_acc = 1'b0;
    tick();
    checks++; if (d16_free !== 1'b1) begin errors++; $display("FAIL t3_idle got %0b want 1", d16_free); end
    $display("txn accept_early: product 12345678 delivered as 5678,1234");
  endtask

  task automatic test_overflow();
    checks++; if (d32_ovf !== 1'b0) begin errors++; $display("FAIL t4_ovf_init got %0b want 0", d32_ovf); end
    d32_res = 32'h40000000; d32_done = 1'b1;
    tick();
    d32_res = 32'h3F800000;
    tick();
    d32_done = 1'b0;
    checks++; if (d32_ovf !== 1'b1) begin errors++; $display("FAIL t4_ovf_set got %0b want 1", d32_ovf); end
    checks++; if (d32_data !== 32'h40000000 || d32_ready !== 1'b1) begin errors++; $display("FAIL t4_kept got data=%h ready=%0b want 40000000/1", d32_data, d32_ready); end
    checks++; if (d32_free !== 1'b0) begin errors++; $display("FAIL t4_busy got %0b want 0", d32_free); end
    d32_done = 1'b1; d32_clr = 1'b1;
    tick();
    d32_done = 1'b0; d32_clr = 1'b0;
    checks++; if (d32_ovf !== 1'b1) begin errors++; $display("FAIL t4_set_wins got %0b want 1", d32_ovf); end
    d32_clr = 1'b1;
    tick();
    d32_clr = 1'b0;
    checks++; if (d32_ovf !== 1'b0) begin errors++; $display("FAIL t4_clr got %0b want 0", d32_ovf); end
    d32_acc = 1'b1;
    tick();
    d32_acc = 1'b0;
    tick();
    checks++; if (d32_free !== 1'b1 || d32_data !== 32'h40000000) begin errors++; $display("FAIL t4_done got free=%0b data=%h want 1/40000000", d32_free, d32_data); end
    $display("txn overflow: 40000000 delivered, 3f800000 dropped");
  endtask

  task automatic test_reset_mid();
    d16_res = 32'hAABBCCDD; d16_done = 1'b1;
    tick();
    d16_done = 1'b0;
    checks++; if (d16_data !== 16'hCCDD) begin errors++; $display("FAIL t5_beat0 got %h want ccdd", d16_data); end
    d16_acc = 1'b1;
    tick();
    checks++; if (d16_ready !== 1'b0 || d16_free !== 1'b0) begin errors++; $display("FAIL t5_release got ready=%0b free=%0b want 0/0", d16_ready, d16_free); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (d16_free !== 1'b1 || d16_ready !== 1'b0) begin errors++; $display("FAIL t5_async got free=%0b ready=%0b want 1/0", d16_free, d16_ready); end
    d16_acc = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    d16_res = 32'h11223344; d16_done = 1'b1;
    tick();
    d16_done = 1'b0;
    checks++; if (d16_ready !== 1'b1 || d16_data !== 16'h3344) begin errors++; $display("FAIL t5_restart got ready=%0b data=%h want 1/3344", d16_ready, d16_data); end
    d16_acc = 1'b1;
    tick();
    d16_acc = 1'b0;
    tick();
    checks++; if (d16_ready !== 1'b1 || d16_data !== 16'h1122) begin errors++; $display("FAIL t5_beat1 got ready=%0b data=%h want 1/1122", d16_ready, d16_data); end
    d16_acc = 1'b1;
    tick();
    d16_acc = 1'b0;
    tick();
    checks++; if (d16_free !== 1'b1) begin errors++; $display("FAIL t5_idle got %0b want 1", d16_free); end
    $display("txn reset_mid: transfer abandoned, 11223344 restarted at beat 0");
  endtask

`ifdef OUT_WRAP_FLAGS_EN
  task automatic test_flags();
    logic [31:0] vecs [3];
    logic [3:0]  exps [3];
    vecs = '{32'h7FC00000, 32'hFF800000, 32'h80000000};
    exps = '{4'b1000, 4'b0101, 4'b0011};
    for (int i = 0; i < 3; i++) begin
      d32_res = vecs[i]; d32_done = 1'b1;
      tick();
      d32_done = 1'b0;
      checks++; if (d32_flags !== exps[i]) begin errors++; $display("FAIL t6_flags_%0d got %b want %b", i, d32_flags, exps[i]); end
      d32_acc = 1'b1;
      tick();
      d32_acc = 1'b0;
      tick();
      checks++; if (d32_flags !== exps[i]) begin errors++; $display("FAIL t6_hold_%0d got %b want %b", i, d32_flags, exps[i]); end
      $display("txn flags: product %h classified %b", vecs[i], d32_flags);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    d32_done = 1'b0; d32_acc = 1'b0; d32_clr = 1'b0; d32_res = '0;
    d16_done = 1'b0; d16_acc = 1'b0; d16_clr = 1'b0; d16_res = '0;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    test_reset();
    test_single_beat();
    test_two_beat();
    test_accept_early();
    test_overflow();
    test_reset_mid();
`ifdef OUT_WRAP_FLAGS_EN
    test_flags();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
